// File: rtl/eva_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_pkg: shared FSM encoding, geometry defaults and lowest-zero encoder
// Rev 1.0
// ----------------------------------------------------------------------------
package eva_pkg;

  localparam int LINES_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_GRANT  = 2'd2,
    ST_RECOMP = 2'd3
  } state_e;

  function automatic logic [ADDR_W_DEF-1:0] first_zero(input logic [LINES_DEF-1:0] bits);
    logic [ADDR_W_DEF-1:0] idx;
    idx = '0;
    for (int i = LINES_DEF - 1; i >= 0; i--) begin
      if (!bits[i]) idx = ADDR_W_DEF'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eva_first_invalid.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_first_invalid: lowest-index invalid line finder over the valid bitmap
// Rev 1.0
// ----------------------------------------------------------------------------
module eva_first_invalid
  import eva_pkg::*;
#(
  parameter int LINES  = LINES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [LINES-1:0]  valid_i,
  output logic              any_invalid_o,
  output logic [ADDR_W-1:0] idx_o
);

  assign any_invalid_o = ~&valid_i;

  generate
    if (LINES == LINES_DEF && ADDR_W == ADDR_W_DEF) begin : g_pkg_enc
      assign idx_o = first_zero(valid_i);
    end else begin : g_loop_enc
      always_comb begin
        idx_o = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
          if (!valid_i[i]) idx_o = ADDR_W'(i);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/eva_victim_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_victim_ctrl: access forwarding, periodic EVA re-rank and victim service
// Rev 1.0
// ----------------------------------------------------------------------------
module eva_victim_ctrl
  import eva_pkg::*;
#(
  parameter int LINES         = LINES_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int UPDATE_PERIOD = 1024,
  parameter int RECOMP_CYCLES = 16,
  parameter int LOOKUP_LAT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              acc_valid_i,
  input  logic              acc_we_i,
  input  logic              acc_hit_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
  input  logic              flush_i,
  input  logic              victim_req_i,
  output logic              victim_gnt_o,
  output logic [ADDR_W-1:0] victim_addr_o,
  output logic              busy_o,
  output logic              ra_re_o,
  output logic              ra_we_o,
  output logic              ra_hit_o,
  output logic              ra_miss_o,
  output logic [ADDR_W-1:0] ra_addr_o,
  output logic              eva_en_o,
  input  logic [ADDR_W-1:0] eva_addr_i,
  output logic              eva_update_o
);

  localparam int CNT_W    = $clog2(UPDATE_PERIOD);
  localparam int DCNT_MAX = (RECOMP_CYCLES > LOOKUP_LAT) ? RECOMP_CYCLES : LOOKUP_LAT;
  localparam int DCNT_W   = $clog2(DCNT_MAX) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(UPDATE_PERIOD - 1);
  localparam logic [DCNT_W-1:0] RECOMP_LOAD = DCNT_W'(RECOMP_CYCLES - 1);
  localparam logic [DCNT_W-1:0] LOOKUP_LOAD = DCNT_W'(LOOKUP_LAT - 1);

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic              pend_q, pend_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] victim_q, victim_d;
  logic              eva_update_q, eva_update_d;
  logic              ra_re_q, ra_we_q, ra_hit_q, ra_miss_q;
  logic [ADDR_W-1:0] ra_addr_q;
  logic              any_invalid;
  logic [ADDR_W-1:0] first_idx;
  logic              wrap;

  eva_first_invalid #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_first_invalid (
    .valid_i       (valid_q),
    .any_invalid_o (any_invalid),
    .idx_o         (first_idx)
  );

  assign wrap = acc_valid_i && (acc_cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ra_re_q   <= 1'b0;
      ra_we_q   <= 1'b0;
      ra_hit_q  <= 1'b0;
      ra_miss_q <= 1'b0;
      ra_addr_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      ra_re_q   <= acc_valid_i & ~acc_we_i;
      ra_we_q   <= acc_valid_i & acc_we_i;
      ra_hit_q  <= acc_valid_i & acc_hit_i;
      ra_miss_q <= acc_valid_i & ~acc_hit_i;
      ra_addr_q <= acc_addr_i;
      // Power-of-two period: natural overflow is the wrap.
      if (acc_valid_i) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      dcnt_q       <= '0;
      pend_q       <= 1'b0;
      valid_q      <= '0;
      victim_q     <= '0;
      eva_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      pend_q       <= pend_d;
      valid_q      <= valid_d;
      victim_q     <= victim_d;
      eva_update_q <= eva_update_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    pend_d       = pend_q;
    victim_d     = victim_q;
    eva_update_d = 1'b0;
    valid_d      = flush_i ? '0 : valid_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d      = ST_RECOMP;
          dcnt_d       = RECOMP_LOAD;
          pend_d       = 1'b0;
          eva_update_d = 1'b1;
        end else if (victim_req_i && any_invalid) begin
          state_d  = ST_GRANT;
          victim_d = first_idx;
        end else if (victim_req_i) begin
          state_d = ST_LOOKUP;
          dcnt_d  = LOOKUP_LOAD;
        end
      end
      ST_LOOKUP: begin
        if (dcnt_q == '0) begin
          victim_d = eva_addr_i;
          state_d  = ST_GRANT;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      ST_GRANT: begin
        // Applied after the flush clear so the granted line survives it.
        valid_d[victim_q] = 1'b1;
        state_d           = ST_IDLE;
      end
      ST_RECOMP: begin
        if (dcnt_q == '0) state_d = ST_IDLE;
        else              dcnt_d  = dcnt_q - DCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // A wrap on the entry cycle re-arms the trigger instead of being lost.
    if (wrap) pend_d = 1'b1;
  end

  assign victim_gnt_o  = (state_q == ST_GRANT);
  assign victim_addr_o = victim_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign eva_en_o      = (state_q == ST_LOOKUP);
  assign eva_update_o  = eva_update_q;
  assign ra_re_o       = ra_re_q;
  assign ra_we_o       = ra_we_q;
  assign ra_hit_o      = ra_hit_q;
  assign ra_miss_o     = ra_miss_q;
  assign ra_addr_o     = ra_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_eva_victim_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_eva_victim_ctrl: directed + randomized bench with a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_eva_victim_ctrl;

  localparam int LINES  = 32;
  localparam int AW     = 5;
  localparam int PERIOD = 1024;
  localparam int RECOMP = 16;
  localparam int LLAT   = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          acc_valid_i, acc_we_i, acc_hit_i;
  logic [AW-1:0] acc_addr_i;
  logic          flush_i, victim_req_i;
  logic          victim_gnt_o;
  logic [AW-1:0] victim_addr_o;
  logic          busy_o, ra_re_o, ra_we_o, ra_hit_o, ra_miss_o;
  logic [AW-1:0] ra_addr_o;
  logic          eva_en_o;
  logic [AW-1:0] eva_addr_i;
  logic          eva_update_o;

  int vectors     = 0;
  int miscompares = 0;
  int acc_mode    = 0;   // 0: no accesses, 1: random, 2: every cycle
  int acc_total   = 0;   // accesses since reset
  bit last_wrap   = 1'b0;
  logic [LINES-1:0] valid_m;
  logic [AW-1:0]    ev;

  always #5 clk_i = ~clk_i;

  eva_victim_ctrl #(
    .LINES         (LINES),
    .ADDR_W        (AW),
    .UPDATE_PERIOD (PERIOD),
    .RECOMP_CYCLES (RECOMP),
    .LOOKUP_LAT    (LLAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .acc_valid_i   (acc_valid_i),
    .acc_we_i      (acc_we_i),
    .acc_hit_i     (acc_hit_i),
    .acc_addr_i    (acc_addr_i),
    .flush_i       (flush_i),
    .victim_req_i  (victim_req_i),
    .victim_gnt_o  (victim_gnt_o),
    .victim_addr_o (victim_addr_o),
    .busy_o        (busy_o),
    .ra_re_o       (ra_re_o),
    .ra_we_o       (ra_we_o),
    .ra_hit_o      (ra_hit_o),
    .ra_miss_o     (ra_miss_o),
    .ra_addr_o     (ra_addr_o),
    .eva_en_o      (eva_en_o),
    .eva_addr_i    (eva_addr_i),
    .eva_update_o  (eva_update_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_inv();
    for (int i = 0; i < LINES; i++) if (!valid_m[i]) return i;
    return -1;
  endfunction

  // One clock: randomize access inputs, advance, check the forwarded copy.
  task automatic tick();
    logic          in_rst, e_re, e_we, e_hit, e_miss;
    logic [AW-1:0] e_addr;
    acc_we_i   = 1'($urandom);
    acc_hit_i  = 1'($urandom);
    acc_addr_i = AW'($urandom);
    case (acc_mode)
      0:       acc_valid_i = 1'b0;
      1:       acc_valid_i = 1'($urandom);
      default: acc_valid_i = 1'b1;
    endcase
    in_rst    = !rst_ni;
    e_re      = acc_valid_i & ~acc_we_i;
    e_we      = acc_valid_i & acc_we_i;
    e_hit     = acc_valid_i & acc_hit_i;
    e_miss    = acc_valid_i & ~acc_hit_i;
    e_addr    = acc_addr_i;
    last_wrap = 1'b0;
    if (in_rst) acc_total = 0;
    else if (acc_valid_i) begin
      acc_total++;
      last_wrap = ((acc_total % PERIOD) == 0);
    end
    @(posedge clk_i);
    #1;
    if (in_rst) begin
      {e_re, e_we, e_hit, e_miss} = 4'b0;
      e_addr = '0;
    end
    chk("ra_re", ra_re_o, e_re);
    chk("ra_we", ra_we_o, e_we);
    chk("ra_hit", ra_hit_o, e_hit);
    chk("ra_miss", ra_miss_o, e_miss);
    chk("ra_addr", ra_addr_o, e_addr);
  endtask

  // One victim request from IDLE; expected path and latency come from the model bitmap.
  task automatic serve(input logic [AW-1:0] e);
    int lat, low;
    logic [AW-1:0] exp_addr;
    low      = lowest_inv();
    lat      = (low >= 0) ? 1 : LLAT + 1;
    exp_addr = (low >= 0) ? AW'(low) : e;
    victim_req_i = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      eva_addr_i = (i == lat) ? e : ~e;
      tick();
      chk("gnt_timing", victim_gnt_o, (i == lat));
      chk("eva_en", eva_en_o, (low < 0 && i < lat));
      chk("busy_serve", busy_o, 1);
    end
    chk("victim_addr", victim_addr_o, exp_addr);
    valid_m[exp_addr] = 1'b1;
    victim_req_i = 1'b0;
    tick();
    chk("gnt_pulse", victim_gnt_o, 0);
    chk("busy_after", busy_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    {acc_valid_i, acc_we_i, acc_hit_i, flush_i, victim_req_i} = 5'b0;
    acc_addr_i = '0;
    eva_addr_i = '0;
    valid_m    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", victim_gnt_o, 0);
    chk("rst_addr", victim_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_eva_en", eva_en_o, 0);
    chk("rst_eva_upd", eva_update_o, 0);
    rst_ni   = 1'b1;
    acc_mode = 1;

    // Cold fill: lowest invalid line first, 1-cycle latency
    for (int k = 0; k < LINES; k++) serve(AW'($urandom));

    // Warm: EVA path
    serve(5'd17);
    for (int k = 0; k < 3; k++) serve(AW'($urandom));

    // Reset in the middle of a lookup
    victim_req_i = 1'b1;
    eva_addr_i   = 5'd3;
    tick();
    chk("lookup_before_rst", eva_en_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_eva_en", eva_en_o, 0);
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_ra_addr", ra_addr_o, 0);
    victim_req_i = 1'b0;
    tick();
    chk("rst_lookup_busy", busy_o, 0);
    chk("rst_lookup_gnt", victim_gnt_o, 0);
    chk("rst_lookup_addr", victim_addr_o, 0);
    rst_ni  = 1'b1;
    valid_m = '0;
    serve(AW'($urandom));

    // Wrap of the access counter, request while re-ranking
    acc_mode = 2;
    for (int g = 0; g < 3000 && !last_wrap; g++) tick();
    chk("wrap_reached", last_wrap, 1);
    acc_mode = 1;
    chk("pre_recomp_upd", eva_update_o, 0);
    chk("pre_recomp_busy", busy_o, 0);
    tick();
    chk("recomp_upd", eva_update_o, 1);
    chk("recomp_busy", busy_o, 1);
    tick();
    chk("recomp_upd_once", eva_update_o, 0);
    victim_req_i = 1'b1;
    ev = AW'($urandom);
    for (int c = 3; c <= RECOMP; c++) begin
      tick();
      chk("recomp_busy_hold", busy_o, 1);
      chk("recomp_no_gnt", victim_gnt_o, 0);
      chk("recomp_no_upd", eva_update_o, 0);
    end
    tick();
    chk("recomp_end_busy", busy_o, 0);
    chk("recomp_end_gnt", victim_gnt_o, 0);
    serve(ev);

    // Fill every line, then wrap while a lookup is in flight
    for (int g = 0; g < LINES && lowest_inv() >= 0; g++) serve(AW'($urandom));
    acc_mode = 2;
    for (int g = 0; g < 3000 && (acc_total % PERIOD) != PERIOD - 1; g++) tick();
    acc_mode = 0;
    ev = AW'($urandom);
    victim_req_i = 1'b1;
    eva_addr_i   = ~ev;
    tick();
    chk("wl_lookup1", eva_en_o, 1);
    acc_mode = 2;
    tick();
    acc_mode = 0;
    chk("wl_wrap_seen", last_wrap, 1);
    chk("wl_lookup2", eva_en_o, 1);
    chk("wl_no_upd_lookup", eva_update_o, 0);
    eva_addr_i = ev;
    tick();
    chk("wl_gnt", victim_gnt_o, 1);
    chk("wl_addr", victim_addr_o, ev);
    chk("wl_no_upd_gnt", eva_update_o, 0);
    victim_req_i = 1'b0;
    tick();
    chk("wl_idle_busy", busy_o, 0);
    chk("wl_idle_upd", eva_update_o, 0);
    tick();
    chk("wl_upd", eva_update_o, 1);
    chk("wl_busy", busy_o, 1);
    for (int c = 2; c <= RECOMP; c++) begin
      tick();
      chk("wl_recomp_busy", busy_o, 1);
      chk("wl_recomp_upd", eva_update_o, 0);
    end
    tick();
    chk("wl_recomp_done", busy_o, 0);
    acc_mode = 1;

    // Flush with all lines valid
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_m = '0;
    serve(AW'($urandom));
    for (int g = 0; g < LINES && lowest_inv() != 9; g++) serve(AW'($urandom));

    // Flush coinciding with the grant of line 9
    victim_req_i = 1'b1;
    tick();
    chk("fg_gnt", victim_gnt_o, 1);
    chk("fg_addr", victim_addr_o, 9);
    victim_req_i = 1'b0;
    flush_i      = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fg_gnt_done", victim_gnt_o, 0);
    valid_m    = '0;
    valid_m[9] = 1'b1;
    for (int k = 0; k < 11; k++) serve(AW'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
